// File: rtl/receptor_serial.sv
// Serial-to-parallel receiver: start, 5 char bits + parity (MSB first), stop -> 6-bit word for the decoder.
// Optional macro RX_PARIDADE_EN adds the registered erro_paridade flag (even parity check).
module receptor_serial #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [5:0] entrada,
  output logic       valido,
  output logic       erro_quadro,
  output logic       ocupado
`ifdef RX_PARIDADE_EN
  ,
  output logic       erro_paridade
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MEIO = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    OCIOSO,
    INICIO,
    DADOS,
    PARADA,
    ESPERA_ALTO
  } estado_t;

  estado_t       r_estado;
  estado_t       w_estado_prox;
  logic [1:0]    r_sync;
  logic          w_rx_s;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_prox;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx_prox;
  logic [5:0]    r_shift;
  logic [5:0]    w_shift_prox;
  logic [5:0]    r_entrada;
  logic          r_valido;
  logic          w_valido_prox;
  logic          r_erro_quadro;
  logic          w_erro_prox;

  assign w_rx_s      = r_sync[1];
  assign entrada     = r_entrada;
  assign valido      = r_valido;
  assign erro_quadro = r_erro_quadro;
  assign ocupado     = (r_estado != OCIOSO);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_estado_prox;
    end
  end

  // Sampling happens at the last count of each bit period, so samples land mid-bit.
  always_comb begin
    w_estado_prox = r_estado;
    w_cnt_prox    = r_cnt + CW'(1);
    w_idx_prox    = r_idx;
    w_shift_prox  = r_shift;
    w_valido_prox = 1'b0;
    w_erro_prox   = 1'b0;
    case (r_estado)
      OCIOSO: begin
        w_cnt_prox = '0;
        if (!w_rx_s) begin
          w_estado_prox = INICIO;
        end
      end
      INICIO: begin
        if (r_cnt == CNT_MEIO) begin
          w_cnt_prox = '0;
          if (!w_rx_s) begin
            w_estado_prox = DADOS;
            w_idx_prox    = 3'd0;
          end else begin
            w_estado_prox = OCIOSO;
          end
        end
      end
      DADOS: begin
        if (r_cnt == CNT_BIT) begin
          w_cnt_prox   = '0;
          w_shift_prox = {r_shift[4:0], w_rx_s};
          if (r_idx == 3'd5) begin
            w_estado_prox = PARADA;
          end else begin
            w_idx_prox = r_idx + 3'd1;
          end
        end
      end
      PARADA: begin
        if (r_cnt == CNT_BIT) begin
          w_cnt_prox = '0;
          if (w_rx_s) begin
            w_valido_prox = 1'b1;
            w_estado_prox = OCIOSO;
          end else begin
            w_erro_prox   = 1'b1;
            w_estado_prox = ESPERA_ALTO;
          end
        end
      end
      ESPERA_ALTO: begin
        w_cnt_prox = '0;
        if (w_rx_s) begin
          w_estado_prox = OCIOSO;
        end
      end
      default: begin
        w_cnt_prox    = '0;
        w_estado_prox = OCIOSO;
      end
    endcase
  end

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync        <= 2'b11;
      r_cnt         <= '0;
      r_idx         <= 3'd0;
      r_shift       <= 6'd0;
      r_entrada     <= 6'd0;
      r_valido      <= 1'b0;
      r_erro_quadro <= 1'b0;
    end else begin
      r_sync        <= {r_sync[0], serial_in};
      r_cnt         <= w_cnt_prox;
      r_idx         <= w_idx_prox;
      r_shift       <= w_shift_prox;
      r_valido      <= w_valido_prox;
      r_erro_quadro <= w_erro_prox;
      if (w_valido_prox) begin
        r_entrada <= r_shift;
      end
    end
  end

`ifdef RX_PARIDADE_EN
  logic r_erro_paridade;

  assign erro_paridade = r_erro_paridade;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_erro_paridade <= 1'b0;
    end else if (w_valido_prox) begin
      r_erro_paridade <= ^r_shift;
    end
  end
`endif

endmodule

// File: tb/tb_receptor_serial.sv
// Self-checking bench for receptor_serial (N=16): directed scenarios plus random frames.
// Build with RX_PARIDADE_EN defined to also check erro_paridade.
module tb_receptor_serial;

  localparam int N = 16;
  localparam int H = N / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b1;
  logic [5:0] entrada;
  logic       valido;
  logic       erro_quadro;
  logic       ocupado;
`ifdef RX_PARIDADE_EN
  logic       erro_paridade;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int         qValCyc[$];
  logic [5:0] qValWord[$];
  logic       qValPar[$];
  int         qErrCyc[$];
  int         qOcRise[$];
  int         qOcFall[$];

  logic       prevOc = 1'b0;
  logic [5:0] prevEntrada = 6'd0;
  logic       rstAtEdge = 1'b1;

  receptor_serial #(.CLKS_PER_BIT(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .entrada      (entrada),
    .valido       (valido),
    .erro_quadro  (erro_quadro),
    .ocupado      (ocupado)
`ifdef RX_PARIDADE_EN
    ,
    .erro_paridade(erro_paridade)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    rstAtEdge <= rst;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Event recorder: cycle numbers are the edge after which the output was seen.
  always @(negedge clk) begin
    if (valido === 1'b1 || erro_quadro === 1'b1) begin
      checkOutput("pulse_exclusive", {31'd0, valido & erro_quadro}, 32'd0);
    end
    if (valido === 1'b1) begin
      qValCyc.push_back(cyc);
      qValWord.push_back(entrada);
`ifdef RX_PARIDADE_EN
      qValPar.push_back(erro_paridade);
`else
      qValPar.push_back(1'b0);
`endif
    end
    if (erro_quadro === 1'b1) qErrCyc.push_back(cyc);
    if (ocupado === 1'b1 && prevOc === 1'b0) qOcRise.push_back(cyc);
    if (ocupado === 1'b0 && prevOc === 1'b1) qOcFall.push_back(cyc);
    if (!rstAtEdge && valido !== 1'b1) begin
      checkOutput("entrada_stable", {26'd0, entrada}, {26'd0, prevEntrada});
    end
    prevOc      = ocupado;
    prevEntrada = entrada;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [5:0] word, input logic stopBit, output int t0);
    serial_in = 1'b0;
    t0 = cyc + 1;
    tick(N);
    for (int i = 5; i >= 0; i--) begin
      serial_in = word[i];
      tick(N);
    end
    serial_in = stopBit;
    tick(N);
  endtask

  task automatic checkFrame(input string tag, input logic [5:0] word, input int t0);
    checkOutput({tag, " valido_count"}, qValCyc.size(), 1);
    if (qValCyc.size() > 0) begin
      checkOutput({tag, " valido_cycle"}, qValCyc.pop_front(), t0 + 2 + H + 7 * N);
      checkOutput({tag, " entrada"}, {26'd0, qValWord.pop_front()}, {26'd0, word});
`ifdef RX_PARIDADE_EN
      checkOutput({tag, " erro_paridade"}, {31'd0, qValPar.pop_front()}, {31'd0, ^word});
`else
      void'(qValPar.pop_front());
`endif
    end
    checkOutput({tag, " erro_quadro_count"}, qErrCyc.size(), 0);
    checkOutput({tag, " ocupado_rise_count"}, qOcRise.size(), 1);
    if (qOcRise.size() > 0) checkOutput({tag, " ocupado_rise"}, qOcRise.pop_front(), t0 + 2);
    checkOutput({tag, " ocupado_fall_count"}, qOcFall.size(), 1);
    if (qOcFall.size() > 0) checkOutput({tag, " ocupado_fall"}, qOcFall.pop_front(), t0 + 2 + H + 7 * N);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " entrada"}, {26'd0, entrada}, 32'd0);
    checkOutput({tag, " valido"}, {31'd0, valido}, 32'd0);
    checkOutput({tag, " erro_quadro"}, {31'd0, erro_quadro}, 32'd0);
    checkOutput({tag, " ocupado"}, {31'd0, ocupado}, 32'd0);
`ifdef RX_PARIDADE_EN
    checkOutput({tag, " erro_paridade"}, {31'd0, erro_paridade}, 32'd0);
`endif
  endtask

  initial begin
    int         t0;
    int         gap;
    logic [5:0] lastWord;
    logic [5:0] w;

    // Scenario 1: reset, then an all-zero frame.
    rst = 1'b1;
    tick(3);
    checkResetOutputs("reset");
    rst = 1'b0;
    tick(2);
    applyStimulus(6'b000000, 1'b1, t0);
    checkFrame("s1_zero", 6'b000000, t0);
    lastWord = 6'b000000;
    tick(N);

    // Scenario 2: two frames back-to-back, 128 cycles apart.
    applyStimulus(6'b100110, 1'b1, t0);
    checkFrame("s2_first", 6'b100110, t0);
    applyStimulus(6'b010110, 1'b1, t0);
    checkFrame("s2_second", 6'b010110, t0);
    lastWord = 6'b010110;
    tick(N);

    // Scenario 3: 4-cycle glitch is rejected at mid start bit.
    serial_in = 1'b0;
    t0 = cyc + 1;
    tick(4);
    serial_in = 1'b1;
    tick(2 * N);
    checkOutput("s3 valido_count", qValCyc.size(), 0);
    checkOutput("s3 erro_quadro_count", qErrCyc.size(), 0);
    checkOutput("s3 entrada", {26'd0, entrada}, {26'd0, lastWord});
    checkOutput("s3 ocupado_rise_count", qOcRise.size(), 1);
    if (qOcRise.size() > 0) checkOutput("s3 ocupado_rise", qOcRise.pop_front(), t0 + 2);
    checkOutput("s3 ocupado_fall_count", qOcFall.size(), 1);
    if (qOcFall.size() > 0) checkOutput("s3 ocupado_fall", qOcFall.pop_front(), t0 + 2 + H);

    // Scenario 4: framing error, line stuck low 50 more cycles, then a good frame.
    applyStimulus(6'b111111, 1'b0, t0);
    tick(50);
    serial_in = 1'b1;
    tick(2 * N);
    checkOutput("s4 erro_quadro_count", qErrCyc.size(), 1);
    if (qErrCyc.size() > 0) checkOutput("s4 erro_quadro_cycle", qErrCyc.pop_front(), t0 + 2 + H + 7 * N);
    checkOutput("s4 valido_count", qValCyc.size(), 0);
    checkOutput("s4 entrada_kept", {26'd0, entrada}, {26'd0, lastWord});
    checkOutput("s4 ocupado_rise_count", qOcRise.size(), 1);
    if (qOcRise.size() > 0) checkOutput("s4 ocupado_rise", qOcRise.pop_front(), t0 + 2);
    checkOutput("s4 ocupado_fall_count", qOcFall.size(), 1);
    if (qOcFall.size() > 0) checkOutput("s4 ocupado_fall", qOcFall.pop_front(), t0 + 8 * N + 52);
    applyStimulus(6'b000001, 1'b1, t0);
    checkFrame("s4_after", 6'b000001, t0);
    lastWord = 6'b000001;
    tick(N);

    // Scenario 5: reset after the third data bit aborts the frame.
    serial_in = 1'b0;
    t0 = cyc + 1;
    tick(N);
    serial_in = 1'b0;
    tick(N);
    serial_in = 1'b1;
    tick(N);
    serial_in = 1'b0;
    tick(N);
    rst = 1'b1;
    serial_in = 1'b1;
    tick(1);
    rst = 1'b0;
    checkResetOutputs("s5_reset");
    lastWord = 6'b000000;
    tick(2 * N);
    checkOutput("s5 valido_count", qValCyc.size(), 0);
    checkOutput("s5 erro_quadro_count", qErrCyc.size(), 0);
    checkOutput("s5 ocupado_rise_count", qOcRise.size(), 1);
    if (qOcRise.size() > 0) checkOutput("s5 ocupado_rise", qOcRise.pop_front(), t0 + 2);
    checkOutput("s5 ocupado_fall_count", qOcFall.size(), 1);
    if (qOcFall.size() > 0) checkOutput("s5 ocupado_fall", qOcFall.pop_front(), t0 + 4 * N);
    applyStimulus(6'b010110, 1'b1, t0);
    checkFrame("s5_after", 6'b010110, t0);
    lastWord = 6'b010110;
    tick(N);

    // Random frames with random idle gaps (gap 0 is back-to-back).
    for (int k = 0; k < 8; k++) begin
      w   = 6'($urandom_range(0, 63));
      gap = $urandom_range(0, 12);
      applyStimulus(w, 1'b1, t0);
      checkFrame("rand", w, t0);
      lastWord = w;
      tick(gap);
    end
    tick(N);
    checkOutput("final entrada", {26'd0, entrada}, {26'd0, lastWord});
    checkOutput("final ocupado", {31'd0, ocupado}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/receptor_serial.md
# receptor_serial

- Serial-to-parallel front end for the character-display path.
- Receives an asynchronous serial frame on one line: start bit, 5 character bits (MSB first), 1 parity bit, stop bit.
- Presents the 6-bit word `{caractere[4:0], paridade}` to the parity-check/7-segment decoder stage, which consumes it as its 6-bit `entrada` input.
- Holds the last good word stable so the display does not flicker while the next frame arrives.

## Interface

- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; even, ≥ 4.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `serial_in` input 1: asynchronous serial line, idle high.
- `entrada` output 6: last received word, `entrada[5:1]` = character, `entrada[0]` = parity bit; wired to the decoder stage.
- `valido` output 1: one-cycle pulse when `entrada` is updated.
- `erro_quadro` output 1: one-cycle pulse on a framing error (stop bit sampled low).
- `ocupado` output 1: high whenever the FSM is not in OCIOSO.
- `erro_paridade` output 1: present only with `RX_PARIDADE_EN`; see Configuration.

Clock/reset: one clock; reset is synchronous and active-high.

## Operation

**Input synchronizer**
- `serial_in` passes through a 2-flop synchronizer; the result is `rx_s`.
- Both synchronizer flops reset to 1.

**Counters**
- Bit-timing counter: width `$clog2(CLKS_PER_BIT)`.
- Bit index: 3 bits.
- Shift register: 6 bits.

**FSM states**
- OCIOSO:
  - `rx_s`=0 → INICIO; counter cleared.
- INICIO:
  - Counter counts to `CLKS_PER_BIT/2 - 1` (mid start bit).
  - If `rx_s`=0 at that point → DADOS; counter and bit index cleared.
  - If `rx_s`=1 (glitch) → OCIOSO; no pulse.
- DADOS:
  - Every `CLKS_PER_BIT` cycles, sample `rx_s` into the shift register LSB, shifting left.
  - After 6 samples (bit index 5) → PARADA.
- PARADA:
  - After `CLKS_PER_BIT` cycles, sample the stop bit.
  - Stop bit 1: load `entrada` from the shift register, pulse `valido`, go to OCIOSO.
  - Stop bit 0: pulse `erro_quadro`, leave `entrada` unchanged, go to ESPERA_ALTO.
- ESPERA_ALTO:
  - Remain until `rx_s`=1, then go to OCIOSO.
  - A line stuck low therefore never produces a second frame.

**Boundary rules**
- `entrada` changes only together with `valido`.
- `valido` and `erro_quadro` are never high in the same cycle.
- `rst` in any state, including mid-frame: FSM to OCIOSO, counters cleared, partial word discarded, no pulse.
- A new start bit immediately after a good stop bit is accepted: OCIOSO sees `rx_s`=0 on the next edge.

**Reset values**
- `entrada`=6'b000000
- `valido`=0
- `erro_quadro`=0
- `ocupado`=0
- `erro_paridade`=0
- state = OCIOSO

## Timing

Let t0 be the first rising edge at which `serial_in` is sampled 0, N=`CLKS_PER_BIT`, H=N/2.

| Event | Clock edge |
|---|---|
| `rx_s` low seen by FSM | t0+2 |
| `ocupado` high | cycle after t0+2 |
| Start bit verified | t0+2+H |
| Data/parity bit k (k=1..6) sampled | t0+2+H+k·N |
| Stop bit sampled | t0+2+H+7·N |

- `valido` (or `erro_quadro`) is high for exactly one cycle, the cycle after the stop-bit edge. For N=16 this is the cycle after edge t0+122.
- `ocupado` falls in the same cycle `valido` rises.
- Minimum frame spacing: 9 bit periods (start + 6 + stop + 1 idle) is not required; 8 bit periods back-to-back is supported.

## Configuration

`RX_PARIDADE_EN`:
- **Defined:**
  - Adds output `erro_paridade`, which is registered with `entrada`.
  - It is asserted with `valido` when the XOR of all 6 received bits is 1 (even parity violated).
  - It is held until the next `valido`.
  - It resets to 0.
  - `entrada` is still updated on a parity error; the decoder stage makes the display decision.
- **Undefined:**
  - No `erro_paridade` port and no parity logic.
  - Behaviour of all other outputs is identical.

## Test plan

All scenarios use N=16.

1. **Reset then frame 000000, stop 1**
   - `valido` pulses once at the cycle after t0+122, `entrada`=000000.
   - With `RX_PARIDADE_EN`, `erro_paridade`=0.
2. **Frame 100110 then frame 010110, back-to-back**
   - Two `valido` pulses 128 cycles apart.
   - `entrada`=100110, then 010110.
   - With `RX_PARIDADE_EN`, `erro_paridade`=1 on both frames (3 ones each).
3. **Glitch: `serial_in` low for 4 cycles, otherwise idle**
   - `ocupado` goes high, then returns low by t0+2+H+1.
   - No `valido`, no `erro_quadro`, `entrada` unchanged.
4. **Frame 111111 with stop bit 0, line held low for 50 more cycles, then high**
   - `erro_quadro` pulses once, `entrada` keeps the previous value, no second start.
   - A following valid frame 000001 is received, with `erro_paridade`=1 when enabled.
5. **`rst` asserted for 1 cycle after the 3rd data bit**
   - All outputs take reset values on the next cycle; no pulse for the aborted frame.
   - The next full frame 010110 is received correctly.
